// File: rtl/glitch_pkg.sv
// -----------------------------------------------------------------------------
// glitch_pkg
// Shared definitions for the glitch sweep controller: the FSM state encoding,
// the default settle / timeout cycle counts and a small step helper.
// -----------------------------------------------------------------------------
package glitch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_SAMPLE    = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam logic [31:0] SETTLE_CYCLES_DEFAULT  = 32'd1000;
    localparam logic [31:0] TIMEOUT_CYCLES_DEFAULT = 32'd12_000_000;

    // A zero step would stall the sweep forever, so it behaves as a step of 1.
    function automatic logic [31:0] nonzero_step(input logic [31:0] step);
        return (step == 32'd0) ? 32'd1 : step;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Combinational step-and-compare unit for one sweep axis (delay or width).
// Adds the (nonzero) step to the current value and reports whether the result
// has left the range, either by exceeding the maximum or by carrying out of
// 32 bits. The caller decides whether to wrap back to the minimum or stop.
//
// Ports:
//   i_value  current axis value
//   i_step   step size (0 behaves as 1)
//   i_max    inclusive upper bound of the axis
//   o_next   i_value + step, truncated to 32 bits
//   o_past   next value is outside the range (above i_max or wrapped)
// -----------------------------------------------------------------------------
module sweep_counter
    import glitch_pkg::*;
(
    input  logic [31:0] i_value,
    input  logic [31:0] i_step,
    input  logic [31:0] i_max,
    output logic [31:0] o_next,
    output logic        o_past
);

    logic [32:0] w_sum;

    assign w_sum  = {1'b0, i_value} + {1'b0, nonzero_step(i_step)};
    assign o_next = w_sum[31:0];
    // The carry bit catches ranges ending near 32'hFFFFFFFF that would
    // otherwise wrap back into low values and look "in range" again.
    assign o_past = w_sum[32] | (w_sum[31:0] > i_max);

endmodule

// File: rtl/glitch_sweep.sv
// -----------------------------------------------------------------------------
// glitch_sweep
// Sweeps a fault-injection campaign over a 2-D grid of (delay, width) points.
// Delay is the inner loop, width the outer loop; each point is attempted a
// configurable number of times. Every attempt issues one arm pulse, waits for
// a rising edge of glitch_done (or a timeout), lets the target settle, then
// reports the target response through a one-cycle result pulse.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   start, abort                 one-cycle control pulses
//   delay_min/max/step           inner-loop range, latched on start
//   width_min/max/step           outer-loop range, latched on start
//   attempts                     glitches per point (0 behaves as 1)
//   glitch_done                  done level from the pulse stage
//   success_in                   target response, sampled once per attempt
//   delay_length, pulse_length   current point driven downstream
//   arm                          one-cycle glitch command
//   busy                         sweep in progress
//   sweep_done                   one-cycle end-of-sweep pulse
//   result_valid                 one-cycle pulse per finished attempt
//   result_success/timeout       attempt outcome, qualified by result_valid
// -----------------------------------------------------------------------------
module glitch_sweep
    import glitch_pkg::*;
#(
    parameter logic [31:0] SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] delay_min,
    input  logic [31:0] delay_max,
    input  logic [31:0] delay_step,
    input  logic [31:0] width_min,
    input  logic [31:0] width_max,
    input  logic [31:0] width_step,
    input  logic [7:0]  attempts,
    input  logic        glitch_done,
    input  logic        success_in,
    output logic [31:0] delay_length,
    output logic [31:0] pulse_length,
    output logic        arm,
    output logic        busy,
    output logic        sweep_done,
    output logic        result_valid,
    output logic        result_success,
    output logic        result_timeout
);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_delay;
    logic [31:0] r_width;
    logic [31:0] r_dmin;
    logic [31:0] r_dmax;
    logic [31:0] r_dstep;
    logic [31:0] r_wmax;
    logic [31:0] r_wstep;
    logic [7:0]  r_attempts;
    logic [7:0]  r_att_cnt;
    logic [31:0] r_cnt;        // timeout counter in WAIT_DONE, settle counter in SETTLE
    logic        r_timeout;
    logic        r_done_prev;

    logic [32:0] w_cnt_inc;
    logic [8:0]  w_att_inc;
    logic [7:0]  w_att_eff;
    logic        w_point_done;
    logic        w_done_rise;
    logic        w_range_empty;
    logic        w_start_ok;
    logic [31:0] w_delay_next;
    logic        w_delay_past;
    logic [31:0] w_width_next;
    logic        w_width_past;

    sweep_counter u_delay_cnt (
        .i_value (r_delay),
        .i_step  (r_dstep),
        .i_max   (r_dmax),
        .o_next  (w_delay_next),
        .o_past  (w_delay_past)
    );

    sweep_counter u_width_cnt (
        .i_value (r_width),
        .i_step  (r_wstep),
        .i_max   (r_wmax),
        .o_next  (w_width_next),
        .o_past  (w_width_past)
    );

    assign w_cnt_inc     = {1'b0, r_cnt} + 33'd1;
    assign w_att_eff     = (r_attempts == 8'd0) ? 8'd1 : r_attempts;
    assign w_att_inc     = {1'b0, r_att_cnt} + 9'd1;
    assign w_point_done  = (w_att_inc >= {1'b0, w_att_eff});
    // r_done_prev holds the level seen in the previous cycle (including the
    // ARM cycle), so a level already high on entry never looks like an edge.
    assign w_done_rise   = glitch_done & ~r_done_prev;
    assign w_range_empty = (delay_min > delay_max) | (width_min > width_max);
    // A start coinciding with abort is dropped.
    assign w_start_ok    = start & ~abort;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = w_range_empty ? ST_FINISH : ST_ARM;
                end
            end
            ST_ARM: begin
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_rise) begin
                    w_state_next = ST_SETTLE;
                end else if (w_cnt_inc >= {1'b0, TIMEOUT_CYCLES}) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_inc >= {1'b0, SETTLE_CYCLES}) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_state_next = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (w_point_done && w_delay_past && w_width_past) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_state_next = ST_ARM;
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Abort overrides every other transition of a running sweep.
        if (abort && (r_state != ST_IDLE) && (r_state != ST_FINISH)) begin
            w_state_next = ST_FINISH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_delay     <= 32'd0;
            r_width     <= 32'd0;
            r_dmin      <= 32'd0;
            r_dmax      <= 32'd0;
            r_dstep     <= 32'd0;
            r_wmax      <= 32'd0;
            r_wstep     <= 32'd0;
            r_attempts  <= 8'd0;
            r_att_cnt   <= 8'd0;
            r_cnt       <= 32'd0;
            r_timeout   <= 1'b0;
            r_done_prev <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_done_prev <= glitch_done;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_dmin     <= delay_min;
                        r_dmax     <= delay_max;
                        r_dstep    <= delay_step;
                        r_wmax     <= width_max;
                        r_wstep    <= width_step;
                        r_attempts <= attempts;
                        r_delay    <= delay_min;
                        r_width    <= width_min;
                        r_att_cnt  <= 8'd0;
                    end
                end
                ST_ARM: begin
                    r_cnt     <= 32'd0;
                    r_timeout <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    if (w_done_rise) begin
                        r_cnt <= 32'd0;
                    end else begin
                        r_cnt <= w_cnt_inc[31:0];
                        if (w_cnt_inc >= {1'b0, TIMEOUT_CYCLES}) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    r_cnt <= w_cnt_inc[31:0];
                end
                ST_ADVANCE: begin
                    // Only move to the next point when another attempt follows;
                    // at sweep end (or abort) the last point stays on the outputs.
                    if (w_state_next == ST_ARM) begin
                        if (!w_point_done) begin
                            r_att_cnt <= w_att_inc[7:0];
                        end else begin
                            r_att_cnt <= 8'd0;
                            if (!w_delay_past) begin
                                r_delay <= w_delay_next;
                            end else begin
                                r_delay <= r_dmin;
                                r_width <= w_width_next;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign delay_length   = r_delay;
    assign pulse_length   = r_width;
    assign arm            = (r_state == ST_ARM);
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign sweep_done     = (r_state == ST_FINISH);
    assign result_valid   = (r_state == ST_SAMPLE);
    assign result_success = result_valid & success_in & ~r_timeout;
    assign result_timeout = result_valid & r_timeout;

endmodule

// File: tb/tb_glitch_sweep.sv
// -----------------------------------------------------------------------------
// tb_glitch_sweep
// Self-checking bench for glitch_sweep. The reference is a list of expected
// (delay, width) attempts built with plain 64-bit loops, plus per-attempt
// timing derived from the glitch_done response the bench itself chooses.
// -----------------------------------------------------------------------------
module tb_glitch_sweep;

    localparam int SETTLE_I = 8;
    localparam int TMO_I    = 100;

    logic        clk = 1'b0;
    logic        reset, start, abort, glitch_done, success_in;
    logic [31:0] delay_min, delay_max, delay_step;
    logic [31:0] width_min, width_max, width_step;
    logic [7:0]  attempts;
    logic [31:0] delay_length, pulse_length;
    logic        arm, busy, sweep_done, result_valid, result_success, result_timeout;

    always #5 clk = ~clk;

    glitch_sweep #(
        .SETTLE_CYCLES  (32'(SETTLE_I)),
        .TIMEOUT_CYCLES (32'(TMO_I))
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .delay_min      (delay_min),
        .delay_max      (delay_max),
        .delay_step     (delay_step),
        .width_min      (width_min),
        .width_max      (width_max),
        .width_step     (width_step),
        .attempts       (attempts),
        .glitch_done    (glitch_done),
        .success_in     (success_in),
        .delay_length   (delay_length),
        .pulse_length   (pulse_length),
        .arm            (arm),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .result_valid   (result_valid),
        .result_success (result_success),
        .result_timeout (result_timeout)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    bit          sweeping = 0;
    logic [31:0] q_d[$];
    logic [31:0] q_w[$];
    int          next_evt = -1;   // cycle of next expected arm or sweep_done
    int          rv_cyc   = -1;   // cycle of expected result_valid
    int          t_arm    = -1;
    int          mode     = 0;    // 0: done edge after gd_dly, 1: never, 2: high from arm on
    int          gd_dly   = 1;
    bit          exp_succ, exp_to;
    int          abort_at = -1;
    int          abort_after_arm = -1;
    int          force_mode = -1;
    int          force_dly  = 1;

    // Observed DUT activity since last start
    logic [31:0] log_d[$];
    logic [31:0] log_w[$];
    int          n_arm, n_res, n_done;
    int          last_arm_cyc, last_rv_gap, last_done_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_points(input logic [31:0] dmin, dmax, dstep,
                                         input logic [31:0] wmin, wmax, wstep,
                                         input logic [7:0] att);
        longint sd, sw;
        int     na;
        q_d.delete();
        q_w.delete();
        if (dmin > dmax || wmin > wmax) return;
        sd = (dstep == 0) ? 64'd1 : longint'(dstep);
        sw = (wstep == 0) ? 64'd1 : longint'(wstep);
        na = (att == 0) ? 1 : int'(att);
        for (longint w = longint'(wmin); w <= longint'(wmax); w += sw)
            for (longint d = longint'(dmin); d <= longint'(dmax); d += sd)
                for (int a = 0; a < na; a++) begin
                    q_d.push_back(d[31:0]);
                    q_w.push_back(w[31:0]);
                end
    endfunction

    // One clock: compare at negedge against the model, then drive inputs.
    task automatic step();
        bit e_arm, e_done, e_rv, e_busy;
        @(negedge clk);
        cyc++;
        e_arm  = sweeping && cyc == next_evt && q_d.size() > 0;
        e_done = sweeping && cyc == next_evt && q_d.size() == 0;
        e_rv   = sweeping && cyc == rv_cyc;
        e_busy = sweeping && !e_done;
        check("ctl_arm_done_rv_busy", {arm, sweep_done, result_valid, busy},
              {e_arm, e_done, e_rv, e_busy});

        if (arm) begin
            log_d.push_back(delay_length);
            log_w.push_back(pulse_length);
            n_arm++;
            last_arm_cyc = cyc;
        end
        if (result_valid) begin
            n_res++;
            last_rv_gap = cyc - last_arm_cyc;
        end
        if (sweep_done) begin
            n_done++;
            last_done_cyc = cyc;
        end

        if (e_arm) begin
            check("delay_length", delay_length, q_d[0]);
            check("pulse_length", pulse_length, q_w[0]);
            void'(q_d.pop_front());
            void'(q_w.pop_front());
            t_arm    = cyc;
            next_evt = -1;
            if (force_mode >= 0) begin
                mode   = force_mode;
                gd_dly = force_dly;
            end else begin
                mode   = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
                gd_dly = int'($urandom_range(1, 40));
            end
            success_in = 1'($urandom_range(0, 1));
            exp_to   = (mode != 0);
            exp_succ = exp_to ? 1'b0 : success_in;
            rv_cyc   = exp_to ? cyc + TMO_I + 1 : cyc + gd_dly + SETTLE_I + 1;
            if (mode == 2) glitch_done = 1'b1;
            if (abort_after_arm >= 0) begin
                abort_at = cyc + abort_after_arm;
                abort_after_arm = -1;
            end
        end
        if (e_rv) begin
            check("result_success", result_success, exp_succ);
            check("result_timeout", result_timeout, exp_to);
            rv_cyc      = -1;
            next_evt    = cyc + 2;
            glitch_done = 1'b0;
        end
        if (e_done) begin
            sweeping = 0;
            next_evt = -1;
            abort_at = -1;
        end

        if (sweeping && rv_cyc >= 0 && mode == 0 && cyc == t_arm + gd_dly)
            glitch_done = 1'b1;

        abort = 1'b0;
        if (sweeping && abort_at >= 0 && cyc == abort_at) begin
            abort       = 1'b1;
            abort_at    = -1;
            q_d.delete();
            q_w.delete();
            rv_cyc      = -1;
            next_evt    = cyc + 1;
            glitch_done = 1'b0;
        end

        // Stray start pulses with fresh ranges while busy must change nothing.
        start = 1'b0;
        if (sweeping && $urandom_range(0, 59) == 0) begin
            start      = 1'b1;
            delay_min  = $urandom;
            delay_max  = $urandom;
            delay_step = $urandom;
            width_min  = $urandom;
            width_max  = $urandom;
            width_step = $urandom;
            attempts   = 8'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        glitch_done = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        sweeping    = 0;
        q_d.delete();
        q_w.delete();
        next_evt = -1;
        rv_cyc   = -1;
        abort_at = -1;
        repeat (n) step();
        reset = 1'b0;
        check("reset_delay_length", delay_length, 64'd0);
        check("reset_pulse_length", pulse_length, 64'd0);
        check("reset_result_bits", {result_success, result_timeout}, 64'd0);
    endtask

    task automatic start_sweep(input logic [31:0] dmin, dmax, dstep,
                               input logic [31:0] wmin, wmax, wstep,
                               input logic [7:0] att);
        delay_min  = dmin;  delay_max = dmax;  delay_step = dstep;
        width_min  = wmin;  width_max = wmax;  width_step = wstep;
        attempts   = att;
        start      = 1'b1;
        log_d.delete();
        log_w.delete();
        n_arm = 0; n_res = 0; n_done = 0;
        last_arm_cyc = 0; last_rv_gap = 0; last_done_cyc = 0;
        t_arm    = -1;
        rv_cyc   = -1;
        sweeping = 1;
        build_points(dmin, dmax, dstep, wmin, wmax, wstep, att);
        next_evt = cyc + 1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sweeping && n < budget) begin
            step();
            n++;
        end
        if (sweeping) begin
            n_vec++;
            n_err++;
            $display("FAIL sweep_budget: still running after %0d cycles, expected sweep end", budget);
            do_reset(2);
        end else begin
            step();   // FINISH -> IDLE, so the next start is accepted
        end
    endtask

    initial begin
        logic [31:0] e41_d[8];
        logic [31:0] e41_w[8];
        logic [31:0] dmin, dspan, wmin, wspan;
        e41_d = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
        e41_w = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'd2};

        reset = 1'b1; start = 1'b0; abort = 1'b0; glitch_done = 1'b0; success_in = 1'b0;
        delay_min = 0; delay_max = 0; delay_step = 0;
        width_min = 0; width_max = 0; width_step = 0; attempts = 0;
        do_reset(3);

        // Three delay points, single width, done 20 cycles after arm.
        force_mode = 0; force_dly = 20;
        start_sweep(32'd10, 32'd30, 32'd10, 32'd5, 32'd5, 32'd1, 8'd1);
        wait_idle(5000);
        check("d40_arm_count", 64'(n_arm), 64'd3);
        for (int i = 0; i < 3; i++)
            check("d40_delay", (i < log_d.size()) ? log_d[i] : 32'hDEAD_BEEF, 32'd10 + 32'(i) * 32'd10);
        check("d40_done_count", 64'(n_done), 64'd1);

        // 2x2 grid, two attempts each, delay as inner loop.
        force_mode = 0; force_dly = 3;
        start_sweep(32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1, 8'd2);
        wait_idle(5000);
        check("d41_result_count", 64'(n_res), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("d41_delay", (i < log_d.size()) ? log_d[i] : 32'hDEAD_BEEF, e41_d[i]);
            check("d41_width", (i < log_w.size()) ? log_w[i] : 32'hDEAD_BEEF, e41_w[i]);
        end

        // glitch_done never arrives: timeout result 101 cycles after arm.
        force_mode = 1;
        start_sweep(32'd7, 32'd7, 32'd1, 32'd3, 32'd3, 32'd1, 8'd1);
        wait_idle(5000);
        check("d42_rv_gap", 64'(last_rv_gap), 64'd101);

        // glitch_done already high at arm: no edge, so it must time out.
        force_mode = 2;
        start_sweep(32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 8'd1);
        wait_idle(5000);
        check("d34_rv_gap", 64'(last_rv_gap), 64'd101);

        // Delay range at the top of 32 bits: one point, no wrap.
        force_mode = 0; force_dly = 2;
        start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd1, 8'd1);
        wait_idle(5000);
        check("d43_arm_count", 64'(n_arm), 64'd1);
        check("d43_delay", (log_d.size() > 0) ? log_d[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFE);

        // Width carry at the top of 32 bits: one point.
        start_sweep(32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 8'd1);
        wait_idle(5000);
        check("wcarry_arm_count", 64'(n_arm), 64'd1);

        // Zero step and zero attempts behave as 1.
        start_sweep(32'd0, 32'd2, 32'd0, 32'd9, 32'd9, 32'd0, 8'd0);
        wait_idle(5000);
        check("zero_step_arm_count", 64'(n_arm), 64'd3);

        // Abort 5 cycles into SETTLE (SETTLE starts at arm+gd_dly+1).
        force_mode = 0; force_dly = 4;
        abort_after_arm = 4 + 5;
        start_sweep(32'd0, 32'd3, 32'd1, 32'd0, 32'd0, 32'd1, 8'd2);
        wait_idle(5000);
        check("d44_result_count", 64'(n_res), 64'd0);
        check("d44_arm_count", 64'(n_arm), 64'd1);
        check("d44_done_gap", 64'(last_done_cyc - last_arm_cyc), 64'd10);
        force_mode = -1;

        // Empty delay range: done with no arm.
        start_sweep(32'd5, 32'd4, 32'd1, 32'd0, 32'd0, 32'd1, 8'd1);
        wait_idle(100);
        check("d45_arm_count", 64'(n_arm), 64'd0);
        check("d45_done_count", 64'(n_done), 64'd1);

        // start together with abort while idle: ignored.
        n_done = 0; n_arm = 0;
        delay_min = 0; delay_max = 3; delay_step = 1;
        width_min = 0; width_max = 0; width_step = 1; attempts = 1;
        start = 1'b1; abort = 1'b1;
        repeat (6) step();
        check("start_abort_arm_count", 64'(n_arm), 64'd0);
        check("start_abort_done_count", 64'(n_done), 64'd0);

        // Reset mid-sweep: everything back to zero, no sweep_done.
        start_sweep(32'd0, 32'd4, 32'd1, 32'd0, 32'd1, 32'd1, 8'd2);
        repeat (40) step();
        do_reset(2);
        repeat (3) step();
        check("reset_mid_done_count", 64'(n_done), 64'd0);

        // Randomised sweeps, some aborted at a random point.
        for (int s = 0; s < 14; s++) begin
            dmin  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom_range(0, 50);
            dspan = $urandom_range(0, 4);
            wmin  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom_range(0, 50);
            wspan = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0 && dmin > 0) dspan = 32'hFFFF_FFFF; // empty range
            start_sweep(dmin, dmin + dspan, $urandom_range(0, 3),
                        wmin, wmin + wspan, $urandom_range(0, 2),
                        8'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0) abort_at = cyc + int'($urandom_range(2, 300));
            wait_idle(20000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
